oci_mem_arbiter: RTL and testbench

- Sysclk-domain arbiter that shares the single-port on-chip debug memory (OCI RAM/ROM) between two requesters: the JTAG debug path (take_action_ocimem_* strobes plus jdo) and the CPU debug-memory slave (Avalon-MM).
- Sequences each access, returns JTAG read data on MonDReg, which feeds the debug-slave wrapper's MonDReg input, and applies round-robin fairness.

---
 rtl/oci_dbg_pkg.sv | 28 ++
 rtl/oci_jtag_req_latch.sv | 88 ++++++++
 rtl/oci_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_oci_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oci_dbg_pkg.sv
// ============================================================================
// Module   : oci_dbg_pkg
// Purpose  : Shared types and JTAG data-field positions for the OCI memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package oci_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_JTAG = 1'b1
    } grant_t;

    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RD_BIT    = 35;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

endpackage

`default_nettype wire

// File: rtl/oci_jtag_req_latch.sv
// ============================================================================
// Module   : oci_jtag_req_latch
// Purpose  : Captures JTAG memory strobes into pending flags, auto-incrementing
//            word address, write-data holding register and sticky overrun.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oci_jtag_req_latch
    import oci_dbg_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_wr_strobe,
    input  logic          i_rd_next,
    input  logic [37:0]   i_jdo,
    input  logic          i_wr_done,
    input  logic          i_rd_done,
    output logic [AW-1:0] o_addr,
    output logic [31:0]   o_wdata,
    output logic          o_rd_pend,
    output logic          o_wr_pend,
    output logic          o_overrun
);

    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_rd_pend;
    logic          r_wr_pend;
    logic          r_overrun;

    logic w_jdo_unused;
    assign w_jdo_unused = ^{i_jdo[37:36], i_jdo[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_pend <= 1'b0;
            r_wr_pend <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_rd_pend <= r_rd_pend & ~i_rd_done;
            r_wr_pend <= r_wr_pend & ~i_wr_done;
            if (i_wr_done || i_rd_done)
                r_addr <= r_addr + 1'b1;

            // An address load while a read is queued would retarget it, so it is refused.
            if (i_load) begin
                if (r_rd_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_addr <= i_jdo[JDO_ADDR_LSB +: AW];
                    if (i_jdo[JDO_RD_BIT])
                        r_rd_pend <= 1'b1;
                end
            end

            if (i_rd_next) begin
                if (r_rd_pend)
                    r_overrun <= 1'b1;
                else
                    r_rd_pend <= 1'b1;
            end

            if (i_wr_strobe) begin
                if (r_wr_pend || i_load) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_wr_pend <= 1'b1;
                    r_wdata   <= i_jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                end
            end
        end
    end

    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_rd_pend = r_rd_pend;
    assign o_wr_pend = r_wr_pend;
    assign o_overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/oci_mem_arbiter.sv
// ============================================================================
// Module   : oci_mem_arbiter
// Purpose  : Round-robin arbiter sharing the single-port OCI memory between the
//            JTAG debug path and the CPU debug slave. Optional macro
//            OCI_MEM_ARB_ROM_PROTECT_EN blocks CPU writes at/above ROM_BASE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oci_mem_arbiter
    import oci_dbg_pkg::*;
#(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] ROM_BASE = 8'hC0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [37:0]   jdo,
    input  logic [AW-1:0] cpu_address,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [31:0]   cpu_writedata,
    input  logic [3:0]    cpu_byteenable,
    output logic          cpu_waitrequest,
    output logic [31:0]   cpu_readdata,
    output logic          cpu_readdatavalid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [3:0]    ram_be,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic [31:0]   MonDReg,
    output logic          jtag_busy,
    output logic          jtag_overrun
);

    state_t        r_state;
    grant_t        r_gnt;
    grant_t        r_last;
    logic          r_is_wr;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [3:0]    r_ram_be;
    logic [31:0]   r_ram_wdata;
    logic          r_cpu_wait;
    logic [31:0]   r_cpu_rdata;
    logic          r_cpu_rvalid;
    logic [31:0]   r_mon;

    logic [AW-1:0] w_jaddr;
    logic [31:0]   w_jwdata;
    logic          w_jrd_pend;
    logic          w_jwr_pend;
    logic          w_jreq;
    logic          w_creq;
    logic          w_wr_done;
    logic          w_rd_done;
    logic          w_rom_block;
    grant_t        w_gnt;

    assign w_wr_done = (r_state == ISSUE) && (r_gnt == GNT_JTAG) && r_is_wr;
    assign w_rd_done = (r_state == RDATA) && (r_gnt == GNT_JTAG);

    oci_jtag_req_latch #(.AW(AW)) u_req_latch (
        .clk         (clk),
        .rst         (reset),
        .i_load      (take_action_ocimem_a),
        .i_wr_strobe (take_action_ocimem_b),
        .i_rd_next   (take_no_action_ocimem_a),
        .i_jdo       (jdo),
        .i_wr_done   (w_wr_done),
        .i_rd_done   (w_rd_done),
        .o_addr      (w_jaddr),
        .o_wdata     (w_jwdata),
        .o_rd_pend   (w_jrd_pend),
        .o_wr_pend   (w_jwr_pend),
        .o_overrun   (jtag_overrun)
    );

`ifdef OCI_MEM_ARB_ROM_PROTECT_EN
    assign w_rom_block = (cpu_address >= ROM_BASE);
`else
    logic w_rom_unused;
    assign w_rom_unused = ^ROM_BASE;
    assign w_rom_block  = 1'b0;
`endif

    assign w_jreq = w_jrd_pend | w_jwr_pend;
    assign w_creq = cpu_read | cpu_write;

    always_comb begin
        w_gnt = GNT_CPU;
        if (w_jreq && w_creq)
            w_gnt = (r_last == GNT_CPU) ? GNT_JTAG : GNT_CPU;
        else if (w_jreq)
            w_gnt = GNT_JTAG;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gnt        <= GNT_CPU;
            r_last       <= GNT_CPU;
            r_is_wr      <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_be     <= 4'h0;
            r_ram_wdata  <= '0;
            r_cpu_wait   <= 1'b1;
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_mon        <= '0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_jreq || w_creq) begin
                        r_gnt   <= w_gnt;
                        r_state <= ISSUE;
                        if (w_gnt == GNT_JTAG) begin
                            r_ram_addr  <= w_jaddr;
                            r_ram_be    <= 4'hF;
                            r_ram_wdata <= w_jwdata;
                            r_is_wr     <= w_jwr_pend;
                            r_ram_we    <= w_jwr_pend;
                        end else begin
                            // Read+write together resolves to a write.
                            r_ram_addr  <= cpu_address;
                            r_ram_be    <= cpu_byteenable;
                            r_ram_wdata <= cpu_writedata;
                            r_is_wr     <= cpu_write;
                            r_ram_we    <= cpu_write & ~w_rom_block;
                            r_cpu_wait  <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    r_ram_we   <= 1'b0;
                    r_cpu_wait <= 1'b1;
                    r_last     <= r_gnt;
                    r_state    <= r_is_wr ? IDLE : RDATA;
                end
                RDATA: begin
                    if (r_gnt == GNT_CPU) begin
                        r_cpu_rdata  <= ram_rdata;
                        r_cpu_rvalid <= 1'b1;
                    end else begin
                        r_mon <= ram_rdata;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu_waitrequest   = r_cpu_wait;
    assign cpu_readdata      = r_cpu_rdata;
    assign cpu_readdatavalid = r_cpu_rvalid;
    assign ram_addr          = r_ram_addr;
    assign ram_we            = r_ram_we;
    assign ram_be            = r_ram_be;
    assign ram_wdata         = r_ram_wdata;
    assign MonDReg           = r_mon;
    assign jtag_busy         = w_jreq | ((r_state != IDLE) && (r_gnt == GNT_JTAG));

endmodule

`default_nettype wire

// File: tb/tb_oci_mem_arbiter.sv
// ============================================================================
// Module   : tb_oci_mem_arbiter
// Purpose  : Self-checking bench for oci_mem_arbiter against a transaction-level
//            golden memory model, with directed and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oci_mem_arbiter;

`ifdef OCI_MEM_ARB_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic [37:0] jdo = '0;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    oci_mem_arbiter #(.AW(8), .ROM_BASE(8'hC0)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .ram_addr                (ram_addr),
        .ram_we                  (ram_we),
        .ram_be                  (ram_be),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem  [256];
    logic [31:0] gold [256];
    logic [7:0]  m_jaddr;
    int          wr_cnt = 0;
    logic [7:0]  lw_addr;
    logic [3:0]  lw_be;
    logic [31:0] lw_data;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hC3, b, ~b, b ^ 8'h5A};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // Memory behind the arbiter: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (ram_we) begin
            for (int k = 0; k < 4; k++)
                if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
        ram_rdata <= mem[ram_addr];
        if (ram_we) begin
            wr_cnt  <= wr_cnt + 1;
            lw_addr <= ram_addr;
            lw_be   <= ram_be;
            lw_data <= ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) gold[i] = init_word(i);
        m_jaddr = 8'h00;
    endtask

    function automatic logic [37:0] ld_jdo(input logic [7:0] a, input bit rd);
        logic [37:0] d;
        d = '0;
        d[17 +: 8] = a;
        d[35] = rd;
        return d;
    endfunction

    function automatic logic [37:0] wr_jdo(input logic [31:0] v);
        logic [37:0] d;
        d = '0;
        d[34:3] = v;
        return d;
    endfunction

    // All tasks start and end on a falling edge.
    task automatic jstrobe(input bit a, input bit b, input bit n, input logic [37:0] d);
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
        jdo = d;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jwait(output int c);
        c = 0;
        while (jtag_busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("jtag_done", {31'b0, jtag_busy}, 32'd0);
    endtask

    task automatic jtag_rd_load(input logic [7:0] a, output int c);
        jstrobe(1'b1, 1'b0, 1'b0, ld_jdo(a, 1'b1));
        jwait(c);
        chk("jtag_rd_load", MonDReg, gold[a]);
        m_jaddr = a + 8'd1;
    endtask

    task automatic jtag_rd_next(output int c);
        jstrobe(1'b0, 1'b0, 1'b1, '0);
        jwait(c);
        chk("jtag_rd_next", MonDReg, gold[m_jaddr]);
        m_jaddr = m_jaddr + 8'd1;
    endtask

    task automatic jtag_wr(input logic [31:0] v, output int c);
        jstrobe(1'b0, 1'b1, 1'b0, wr_jdo(v));
        jwait(c);
        gold[m_jaddr] = v;
        m_jaddr = m_jaddr + 8'd1;
    endtask

    task automatic cpu_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] be, output int waits, output int lat);
        int c;
        cpu_address = a; cpu_write = wr; cpu_read = !wr;
        cpu_writedata = d; cpu_byteenable = be;
        waits = 0; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cpu_waitrequest) waits++;
        end while (cpu_waitrequest && waits < 20);
        chk("cpu_accept", {31'b0, cpu_waitrequest}, 32'd0);
        @(negedge clk);
        lat++;
        cpu_read = 1'b0; cpu_write = 1'b0;
        if (wr) begin
            if (!(PROT && a >= 8'hC0)) gold[a] = merge(gold[a], d, be);
        end else begin
            c = 0;
            while (!cpu_readdatavalid && c < 20) begin
                @(negedge clk);
                lat++; c++;
            end
            chk("cpu_rvalid", {31'b0, cpu_readdatavalid}, 32'd1);
            chk("cpu_rdata", cpu_readdata, gold[a]);
        end
    endtask

    initial begin
        int c1, w1, l1, cnt0, rv, bad;
        logic [31:0] d1, d2;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_wait",    {31'b0, cpu_waitrequest},   32'd1);
        chk("rst_rvalid",  {31'b0, cpu_readdatavalid}, 32'd0);
        chk("rst_rdata",   cpu_readdata, 32'd0);
        chk("rst_mon",     MonDReg, 32'd0);
        chk("rst_busy",    {31'b0, jtag_busy}, 32'd0);
        chk("rst_overrun", {31'b0, jtag_overrun}, 32'd0);
        chk("rst_we",      {31'b0, ram_we}, 32'd0);
        chk("rst_addr",    {24'b0, ram_addr}, 32'd0);

        // JTAG read pending and CPU read in the same cycle: JTAG wins the first tie.
        fork
            jtag_rd_load(8'h10, c1);
            begin
                @(negedge clk);
                cpu_xfer(1'b0, 8'h20, '0, 4'hF, w1, l1);
            end
        join
        chk("tie_jtag_lat", c1, 32'd3);
        chk("tie_cpu_wait", w1, 32'd3);

        jtag_rd_next(c1);
        chk("jrd_next_lat", c1, 32'd3);

        jstrobe(1'b1, 1'b0, 1'b0, ld_jdo(8'hFF, 1'b0));
        m_jaddr = 8'hFF;
        chk("load_only_idle", {31'b0, jtag_busy}, 32'd0);
        cnt0 = wr_cnt;
        jtag_wr(32'h12345678, c1);
        chk("jwr_lat",  c1, 32'd2);
        chk("jwr_cnt",  wr_cnt - cnt0, 32'd1);
        chk("jwr_addr", {24'b0, lw_addr}, 32'h000000FF);
        chk("jwr_be",   {28'b0, lw_be}, 32'hF);
        chk("jwr_data", lw_data, 32'h12345678);
        jtag_rd_next(c1);

        d1 = $urandom;
        cpu_xfer(1'b1, 8'h30, d1, 4'($urandom_range(1, 15)), w1, l1);
        chk("cpu_wr_wait", w1, 32'd0);
        cpu_xfer(1'b0, 8'h30, '0, 4'hF, w1, l1);
        chk("cpu_rd_wait", w1, 32'd0);
        chk("cpu_rd_lat",  l1, 32'd3);

        // Back-to-back write strobes: the second is dropped.
        d1 = $urandom; d2 = ~d1;
        cnt0 = wr_cnt;
        take_action_ocimem_b = 1'b1; jdo = wr_jdo(d1);
        @(negedge clk);
        jdo = wr_jdo(d2);
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        jwait(c1);
        chk("ovr_set",  {31'b0, jtag_overrun}, 32'd1);
        chk("ovr_cnt",  wr_cnt - cnt0, 32'd1);
        chk("ovr_data", lw_data, d1);
        gold[m_jaddr] = d1;
        m_jaddr = m_jaddr + 8'd1;
        jtag_rd_load(m_jaddr - 8'd1, c1);

        cpu_xfer(1'b1, 8'hC0, 32'hCAFEF00D, 4'hF, w1, l1);
        chk("rom_cpu_wait", w1, 32'd0);
        jtag_rd_load(8'hC0, c1);
        jstrobe(1'b1, 1'b0, 1'b0, ld_jdo(8'hC0, 1'b0));
        m_jaddr = 8'hC0;
        cnt0 = wr_cnt;
        jtag_wr(32'h0BADF00D, c1);
        chk("rom_jtag_we", wr_cnt - cnt0, 32'd1);
        cpu_xfer(1'b0, 8'hC0, '0, 4'hF, w1, l1);

        // Concurrent traffic in disjoint regions: CPU 0x00-0x3F, JTAG 0x40-0x7F.
        fork
            begin : g_jtag_thread
                int c;
                jtag_rd_load(8'h40, c);
                repeat (14) begin
                    if (m_jaddr < 8'h40 || m_jaddr > 8'h7E)
                        jtag_rd_load(8'h40 + 8'($urandom_range(0, 60)), c);
                    else if ($urandom_range(0, 1) == 1)
                        jtag_wr($urandom, c);
                    else
                        jtag_rd_next(c);
                    chk("jtag_lat_bound", {31'b0, c <= 6}, 32'd1);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin : g_cpu_thread
                int w, l;
                repeat (30) begin
                    cpu_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom,
                             4'($urandom_range(1, 15)), w, l);
                    chk("cpu_wait_bound", {31'b0, w <= 3}, 32'd1);
                end
            end
        join
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== gold[i]) bad++;
        chk("mem_final", bad, 32'd0);
        chk("ovr_sticky", {31'b0, jtag_overrun}, 32'd1);

        // Reset while a CPU read is in its data phase.
        chk("pre_rst_mon", {31'b0, MonDReg != 32'd0}, 32'd1);
        cpu_address = 8'h05; cpu_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; cpu_read = 1'b0;
        rv = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_readdatavalid) rv++;
        end
        reset = 1'b0;
        model_reset();
        chk("midrst_rvalid",  rv, 32'd0);
        chk("midrst_mon",     MonDReg, 32'd0);
        chk("midrst_wait",    {31'b0, cpu_waitrequest}, 32'd1);
        chk("midrst_overrun", {31'b0, jtag_overrun}, 32'd0);

        // Load and write strobes together: the load executes, the write is dropped.
        cnt0 = wr_cnt;
        jstrobe(1'b1, 1'b1, 1'b0, ld_jdo(8'h50, 1'b1));
        jwait(c1);
        chk("ab_overrun", {31'b0, jtag_overrun}, 32'd1);
        chk("ab_mon",     MonDReg, gold[8'h50]);
        chk("ab_no_wr",   wr_cnt - cnt0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
